rec_tran_rx: RTL and testbench

//  Receive end of the serial OTN link. Recovers bit timing from i_otn_rx_data and hunts the FAS
//  (F6 F6 F6 28 28 28, LSB-first). Deserializes one frame and checks its XOR checksum, then returns
//  a one-bit ACK on o_otn_tx_ack (3-symbol start/ack/stop) that the sender's ARQ FSM consumes.

---
 rtl/rec_tran_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_rec_tran_rx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_tran_rx.sv
// rec_tran_rx: OTN serial receiver - bit recovery, FAS hunt, checksum, ARQ ACK.
// Optional REC_NACK_INJECT_EN adds i_force_nack to force a NACK in CHECK.
module rec_tran_rx #(
  parameter int FRAME_BYTES    = 4165,
  parameter int TICKS_PER_BIT  = 20,
  parameter int ACK_SYM_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
`ifdef REC_NACK_INJECT_EN
  input  logic       i_force_nack,
`endif
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_good,
  output logic [7:0] o_bad_frame_cnt,
  output logic       o_otn_tx_ack
);

  localparam int PW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int SW = (ACK_SYM_CYCLES > 1) ? $clog2(ACK_SYM_CYCLES) : 1;

  localparam logic [47:0]   FAS        = 48'h282828F6F6F6;
  localparam logic [PW-1:0] PH_LAST    = PW'(TICKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_MID     = PW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BYTES_LAST = BW'(FRAME_BYTES - 1);
  localparam logic [BW-1:0] BYTES_FAS  = BW'(6);
  localparam logic [SW-1:0] SYM_LAST   = SW'(ACK_SYM_CYCLES - 1);

  typedef enum logic [2:0] {
    HUNT,
    RECV,
    CHECK,
    ACK_START,
    ACK_BIT,
    ACK_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync_q, sync_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [47:0]   hunt_q, hunt_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic [SW-1:0] sym_q, sym_d;
  logic          ack_bit_q, ack_bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          good_q, good_d;
  logic [7:0]    bad_cnt_q, bad_cnt_d;
  logic          tx_q, tx_d;

  logic          force_nack;
  logic          edge_w;
  logic          sample;
  logic          rx_bit;
  logic [47:0]   shift_h;
  logic [7:0]    shift_b;
  logic          good_w;

`ifdef REC_NACK_INJECT_EN
  assign force_nack = i_force_nack;
`else
  assign force_nack = 1'b0;
`endif

  // Edge resyncs the bit phase and suppresses a coincident sample.
  assign rx_bit  = sync_q[2];
  assign edge_w  = sync_q[2] ^ sync_q[3];
  assign sample  = i_sclk_en_16_x_baud & ~edge_w
                 & (phase_q == PH_MID);
  assign shift_h = {rx_bit, hunt_q[47:1]};
  assign shift_b = {rx_bit, byte_q[7:1]};
  assign good_w  = (xor_q == 8'h00) & ~force_nack;

  always_comb begin
    sync_d     = {sync_q[2:0], i_otn_rx_data};
    phase_d    = phase_q;
    state_d    = state_q;
    hunt_d     = hunt_q;
    byte_d     = byte_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    sym_d      = sym_q;
    ack_bit_d  = ack_bit_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    good_d     = good_q;
    bad_cnt_d  = bad_cnt_q;
    tx_d       = tx_q;

    if (edge_w) begin
      phase_d = '0;
    end else if (i_sclk_en_16_x_baud) begin
      if (phase_q == PH_LAST) phase_d = '0;
      else                    phase_d = phase_q + PW'(1);
    end

    case (state_q)
      HUNT: begin
        if (sample) begin
          hunt_d = shift_h;
          if (shift_h == FAS) begin
            start_d    = 1'b1;
            state_d    = RECV;
            hunt_d     = '0;
            byte_d     = '0;
            byte_cnt_d = BYTES_FAS;
            bit_cnt_d  = '0;
            xor_d      = '0;
          end
        end
      end
      RECV: begin
        if (sample) begin
          byte_d    = shift_b;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d     = shift_b;
            valid_d    = 1'b1;
            xor_d      = xor_q ^ shift_b;
            byte_cnt_d = byte_cnt_q + BW'(1);
            if (byte_cnt_q == BYTES_LAST) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        done_d    = 1'b1;
        good_d    = good_w;
        ack_bit_d = good_w;
        hunt_d    = '0;
        sym_d     = '0;
        if (!good_w && bad_cnt_q != 8'hFF)
          bad_cnt_d = bad_cnt_q + 8'd1;
        if (i_arq_en) begin
          state_d = ACK_START;
          tx_d    = 1'b0;
        end else begin
          state_d = HUNT;
        end
      end
      ACK_START: begin
        if (sym_q == SYM_LAST) begin
          sym_d   = '0;
          state_d = ACK_BIT;
          tx_d    = ack_bit_q;
        end else begin
          sym_d = sym_q + SW'(1);
        end
      end
      ACK_BIT: begin
        if (sym_q == SYM_LAST) begin
          sym_d   = '0;
          state_d = ACK_STOP;
          tx_d    = 1'b0;
        end else begin
          sym_d = sym_q + SW'(1);
        end
      end
      ACK_STOP: begin
        if (sym_q == SYM_LAST) begin
          sym_d   = '0;
          state_d = HUNT;
          tx_d    = 1'b1;
        end else begin
          sym_d = sym_q + SW'(1);
        end
      end
      default: begin
        state_d = HUNT;
        hunt_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= HUNT;
      sync_q     <= '0;
      phase_q    <= '0;
      hunt_q     <= '0;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      xor_q      <= '0;
      sym_q      <= '0;
      ack_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      bad_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      phase_q    <= phase_d;
      hunt_q     <= hunt_d;
      byte_q     <= byte_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      xor_q      <= xor_d;
      sym_q      <= sym_d;
      ack_bit_q  <= ack_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      good_q     <= good_d;
      bad_cnt_q  <= bad_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign o_data          = data_q;
  assign o_data_valid    = valid_q;
  assign o_frame_start   = start_q;
  assign o_frame_done    = done_q;
  assign o_frame_good    = good_q;
  assign o_bad_frame_cnt = bad_cnt_q;
  assign o_otn_tx_ack    = tx_q;

endmodule

// File: tb/tb_rec_tran_rx.sv
// Bench for rec_tran_rx: table frames, hand sequences, random frames vs model,
// plus a fast second instance that drives the bad-frame counter to saturation.
module tb_rec_tran_rx;

  localparam int TPB   = 20;
  localparam int S_TPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       arq = 1'b0;
  logic       force_nack = 1'b0;
  logic [7:0] o_data;
  logic       o_data_valid, o_frame_start, o_frame_done, o_frame_good;
  logic [7:0] o_bad_frame_cnt;
  logic       o_otn_tx_ack;

  logic       rst_s = 1'b1;
  logic       rx_s = 1'b1;
  logic       arq_s = 1'b0;
  logic       nack_s = 1'b0;
  logic [7:0] s_data;
  logic       s_valid, s_start, s_done, s_good;
  logic [7:0] s_cnt;
  logic       s_tx;

  rec_tran_rx #(
    .FRAME_BYTES(16), .TICKS_PER_BIT(TPB), .ACK_SYM_CYCLES(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sclk_en_16_x_baud(1'b1),
    .i_otn_rx_data(rx),
    .i_arq_en(arq),
`ifdef REC_NACK_INJECT_EN
    .i_force_nack(force_nack),
`endif
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .o_frame_start(o_frame_start),
    .o_frame_done(o_frame_done),
    .o_frame_good(o_frame_good),
    .o_bad_frame_cnt(o_bad_frame_cnt),
    .o_otn_tx_ack(o_otn_tx_ack)
  );

  rec_tran_rx #(
    .FRAME_BYTES(7), .TICKS_PER_BIT(S_TPB), .ACK_SYM_CYCLES(1)
  ) dut_sat (
    .i_clk(clk),
    .i_rst(rst_s),
    .i_sclk_en_16_x_baud(1'b1),
    .i_otn_rx_data(rx_s),
    .i_arq_en(arq_s),
`ifdef REC_NACK_INJECT_EN
    .i_force_nack(nack_s),
`endif
    .o_data(s_data),
    .o_data_valid(s_valid),
    .o_frame_start(s_start),
    .o_frame_done(s_done),
    .o_frame_good(s_good),
    .o_bad_frame_cnt(s_cnt),
    .o_otn_tx_ack(s_tx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Main-instance monitor
  logic [7:0] got_q[$];
  logic       good_q[$];
  logic [3:0] ack_q[$];
  int start_cnt = 0;
  int done_cnt = 0;

  initial begin
    int aw;
    logic [3:0] as;
    aw = 0;
    as = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw = 0;
      end else begin
        if (o_data_valid) got_q.push_back(o_data);
        if (o_frame_start) start_cnt++;
        if (aw > 0) begin
          as = {as[2:0], o_otn_tx_ack};
          aw--;
          if (aw == 0) ack_q.push_back(as);
        end
        if (o_frame_done) begin
          done_cnt++;
          good_q.push_back(o_frame_good);
          as = {3'b000, o_otn_tx_ack};
          aw = 3;
        end
      end
    end
  end

  // Saturation-instance monitor
  int s_done_cnt = 0;
  int s_bytes = 0;
  int s_starts = 0;
  int s_good_seen = 0;
  int s_tx_low = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_s) begin
        if (s_done) s_done_cnt++;
        if (s_done && s_good) s_good_seen++;
        if (s_valid && s_data == 8'h5A) s_bytes++;
        if (s_start) s_starts++;
        if (!s_tx) s_tx_low++;
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (TPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_fas();
    repeat (3) send_byte(8'hF6);
    repeat (3) send_byte(8'h28);
  endtask

  task automatic send_pl(input logic [7:0] pl[10]);
    for (int i = 0; i < 10; i++) send_byte(pl[i]);
  endtask

  task automatic wait_done(input string tag, input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_cnt"}, done_cnt, target);
    repeat (6) @(negedge clk);
  endtask

  function automatic logic model_good(input logic [7:0] pl[10],
                                      input logic fn);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 10; i++) x ^= pl[i];
    return (x == 8'h00) && !fn;
  endfunction

  function automatic logic [7:0] model_cnt(input logic [7:0] c,
                                           input logic g);
    if (g || c == 8'd255) return c;
    return c + 8'd1;
  endfunction

  function automatic logic [3:0] model_ack(input logic a, input logic g);
    return a ? {1'b0, g, 1'b0, 1'b1} : 4'b1111;
  endfunction

  task automatic do_frame(input string tag, input int pre_bits,
                          input bit partial, input logic [7:0] pl[10],
                          input logic a, input logic exp_good,
                          input logic [7:0] exp_cnt);
    int d0, s0;
    d0 = done_cnt;
    s0 = start_cnt;
    got_q.delete();
    good_q.delete();
    ack_q.delete();
    arq = a;
    for (int i = 0; i < pre_bits; i++) send_bit(1'($urandom_range(0, 1)));
    if (partial) begin
      send_byte(8'hF6);
      send_byte(8'hF6);
      send_byte(8'h28);
    end
    send_fas();
    send_pl(pl);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_done(tag, d0 + 1);
    check({tag, "_starts"}, start_cnt - s0, 1);
    check({tag, "_nbytes"}, got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], pl[i]);
    check({tag, "_ngood"}, good_q.size(), 1);
    if (good_q.size() > 0) check({tag, "_good"}, good_q[0], exp_good);
    check({tag, "_nack"}, ack_q.size(), 1);
    if (ack_q.size() > 0)
      check({tag, "_ack"}, ack_q[0], model_ack(a, exp_good));
    check({tag, "_badcnt"}, o_bad_frame_cnt, exp_cnt);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"}, o_data, 8'h00);
    check({tag, "_valid"}, o_data_valid, 1'b0);
    check({tag, "_start"}, o_frame_start, 1'b0);
    check({tag, "_done"}, o_frame_done, 1'b0);
    check({tag, "_good"}, o_frame_good, 1'b0);
    check({tag, "_cnt"}, o_bad_frame_cnt, 8'h00);
    check({tag, "_ack"}, o_otn_tx_ack, 1'b1);
  endtask

  typedef struct {
    int         pre_bits;
    bit         partial;
    logic [7:0] cks;
    logic       arq;
    logic       exp_good;
    logic [7:0] exp_cnt;
  } vec_t;

  task automatic main_seq();
    vec_t vt[5];
    logic [7:0] pl[10];
    logic [7:0] good_pl[10];
    logic [7:0] mcnt;
    logic g;
    int d0, s0, t;

    vt[0] = '{0,  1'b0, 8'h01, 1'b1, 1'b1, 8'd0};
    vt[1] = '{0,  1'b0, 8'h00, 1'b1, 1'b0, 8'd1};
    vt[2] = '{0,  1'b0, 8'h01, 1'b1, 1'b1, 8'd1};
    vt[3] = '{12, 1'b1, 8'h01, 1'b1, 1'b1, 8'd1};
    vt[4] = '{0,  1'b0, 8'h01, 1'b0, 1'b1, 8'd1};
    for (int i = 0; i < 9; i++) good_pl[i] = 8'(i + 1);
    good_pl[9] = 8'h01;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Reset held 5 cycles mid-frame, then 200 idle cycles.
    arq = 1'b1;
    send_fas();
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("rst_mid");
    d0 = done_cnt;
    s0 = start_cnt;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_start", start_cnt - s0, 0);

    // Reset during the ACK: line must return high the next cycle.
    arq = 1'b1;
    fork
      begin
        send_fas();
        send_pl(good_pl);
        send_bit(1'b1);
      end
      begin
        t = 0;
        while (!o_frame_done && t < 4000) begin
          @(negedge clk);
          t++;
        end
        check("ackrst_done", o_frame_done, 1'b1);
        check("ackrst_line_low", o_otn_tx_ack, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ackrst_line_high", o_otn_tx_ack, 1'b1);
        check("ackrst_no_done", o_frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      pl = good_pl;
      pl[9] = vt[v].cks;
      do_frame($sformatf("vec%0d", v), vt[v].pre_bits, vt[v].partial,
               pl, vt[v].arq, vt[v].exp_good, vt[v].exp_cnt);
    end

    // Back-to-back frames with ARQ off.
    got_q.delete();
    good_q.delete();
    ack_q.delete();
    d0 = done_cnt;
    s0 = start_cnt;
    arq = 1'b0;
    send_fas();
    send_pl(good_pl);
    send_fas();
    send_pl(good_pl);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_done("b2b", d0 + 2);
    check("b2b_starts", start_cnt - s0, 2);
    check("b2b_nbytes", got_q.size(), 20);
    for (int i = 0; i < 20 && i < got_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), got_q[i], good_pl[i % 10]);
    check("b2b_ngood", good_q.size(), 2);
    for (int i = 0; i < good_q.size(); i++)
      check($sformatf("b2b_good%0d", i), good_q[i], 1'b1);
    for (int i = 0; i < ack_q.size(); i++)
      check($sformatf("b2b_ack%0d", i), ack_q[i], 4'b1111);
    check("b2b_badcnt", o_bad_frame_cnt, 8'd1);

    // Random frames against the behavioural model.
    mcnt = vt[4].exp_cnt;
    for (int f = 0; f < 6; f++) begin
      logic a;
      for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
      pl[9] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pl[9] = 8'h00;
        for (int i = 0; i < 9; i++) pl[9] ^= pl[i];
      end
      a = 1'($urandom_range(0, 1));
      g = model_good(pl, 1'b0);
      mcnt = model_cnt(mcnt, g);
      do_frame($sformatf("rnd%0d", f), $urandom_range(0, 7), 1'b0,
               pl, a, g, mcnt);
    end

`ifdef REC_NACK_INJECT_EN
    force_nack = 1'b1;
    g = model_good(good_pl, 1'b1);
    mcnt = model_cnt(mcnt, g);
    do_frame("nack", 0, 1'b0, good_pl, 1'b1, g, mcnt);
    force_nack = 1'b0;
`endif
  endtask

  task automatic sbit(input logic b);
    rx_s = b;
    repeat (S_TPB) @(negedge clk);
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sbit(b[i]);
  endtask

  task automatic sat_seq();
    logic [7:0] m;
    m = 8'd0;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      repeat (3) sbyte(8'hF6);
      repeat (3) sbyte(8'h28);
      sbyte(8'h5A);
      repeat (3) sbit(1'b1);
      m = model_cnt(m, 1'b0);
      if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256)
        check($sformatf("sat_cnt_after_%0d", k), s_cnt, m);
    end
    check("sat_done_cnt", s_done_cnt, 256);
    check("sat_starts", s_starts, 256);
    check("sat_bytes", s_bytes, 256);
    check("sat_good_seen", s_good_seen, 0);
    check("sat_tx_low", s_tx_low, 0);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
